// File: rtl/varint_decoder_pkg.sv
// rtl/varint_decoder_pkg.sv - shared state type and widths for the varint decoder
package varint_decoder_pkg;

    localparam int VARINT_MAX_BYTES = 10;
    localparam int INDEX_W          = 10;
    localparam int DATA_W           = 32;
    localparam int VALUE_W          = 64;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EMIT   = 2'd2
    } state_t;

endpackage

// File: rtl/varint_decoder_byte_acc.sv
// rtl/varint_decoder_byte_acc.sv - varint_byte_acc: 7-bit group shift-or accumulator with overflow flag
module varint_byte_acc
    import varint_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               clear,
    input  logic [7:0]         byte_in,
    output logic [VALUE_W-1:0] acc,
    output logic [3:0]         cnt,
    output logic [VALUE_W-1:0] acc_next,
    output logic [3:0]         cnt_next,
    output logic               overflow
);

    logic [6:0] shamt;

    // Groups past bit 63 fall off the top; the 10th continuation byte flags overflow.
    always_comb begin
        shamt    = 7'(cnt) * 7'd7;
        acc_next = acc | (VALUE_W'(byte_in[6:0]) << shamt);
        cnt_next = cnt + 4'd1;
        overflow = byte_in[7] && (cnt_next == 4'(VARINT_MAX_BYTES));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
            cnt <= 4'd0;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/varint_decoder.sv
// rtl/varint_decoder.sv - pops 32-bit words plus record index and emits decoded LEB128 varints
module varint_decoder
    import varint_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               varint_fifo_empty,
    input  logic [DATA_W-1:0]  varint_fifo_data,
    output logic               varint_fifo_pop,
    input  logic               varint_index_empty,
    input  logic [INDEX_W-1:0] varint_index_data,
    output logic               varint_index_pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VALUE_W-1:0] out_value,
    output logic [INDEX_W-1:0] out_index,
    output logic [3:0]         out_nbytes,
    output logic               out_error,
    output logic [31:0]        decoded_count
);

    state_t             state;
    logic               pop;
    logic [DATA_W-1:0]  word_reg;
    logic [INDEX_W-1:0] new_index;
    logic [INDEX_W-1:0] acc_index;
    logic [1:0]         byte_ptr;
    logic               restart;
    logic [7:0]         cur_byte;
    logic [VALUE_W-1:0] acc;
    logic [VALUE_W-1:0] acc_next;
    logic [3:0]         cnt;
    logic [3:0]         cnt_next;
    logic               overflow;
    logic               step;
    logic               clear;
    logic               heads_valid;

    assign varint_fifo_pop  = pop;
    assign varint_index_pop = pop;
    assign heads_valid      = !varint_fifo_empty && !varint_index_empty;
    assign cur_byte         = word_reg[{byte_ptr, 3'b000} +: 8];
    assign step             = (state == DECODE);
    assign clear            = (state == EMIT) && out_ready;

    varint_byte_acc u_byte_acc (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .clear    (clear),
        .byte_in  (cur_byte),
        .acc      (acc),
        .cnt      (cnt),
        .acc_next (acc_next),
        .cnt_next (cnt_next),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            pop           <= 1'b0;
            word_reg      <= '0;
            new_index     <= '0;
            acc_index     <= '0;
            byte_ptr      <= 2'd0;
            restart       <= 1'b0;
            out_valid     <= 1'b0;
            out_value     <= '0;
            out_index     <= '0;
            out_nbytes    <= 4'd0;
            out_error     <= 1'b0;
            decoded_count <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    // The word is captured while pop is raised; the pop cycle itself decides the next step.
                    if (pop) begin
                        pop <= 1'b0;
                        if (cnt != 4'd0 && new_index != acc_index) begin
                            out_value  <= acc;
                            out_index  <= acc_index;
                            out_nbytes <= cnt;
                            out_error  <= 1'b1;
                            out_valid  <= 1'b1;
                            restart    <= 1'b1;
                            state      <= EMIT;
                        end else begin
                            state <= DECODE;
                        end
                    end else if (heads_valid) begin
                        pop       <= 1'b1;
                        word_reg  <= varint_fifo_data;
                        new_index <= varint_index_data;
                        byte_ptr  <= 2'd0;
                    end
                end
                DECODE: begin
                    if (cnt == 4'd0) begin
                        acc_index <= new_index;
                    end
                    if (!cur_byte[7] || overflow) begin
                        out_value  <= acc_next;
                        out_index  <= (cnt == 4'd0) ? new_index : acc_index;
                        out_nbytes <= cnt_next;
                        out_error  <= overflow;
                        out_valid  <= 1'b1;
                        state      <= EMIT;
                    end else if (byte_ptr == 2'd3) begin
                        state <= FETCH;
                    end else begin
                        byte_ptr <= byte_ptr + 2'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!out_error) begin
                            decoded_count <= decoded_count + 32'd1;
                        end
                        // After a flushed partial, the fresh word still starts at byte 0.
                        if (restart) begin
                            restart <= 1'b0;
                            state   <= DECODE;
                        end else if (byte_ptr == 2'd3) begin
                            state <= FETCH;
                        end else begin
                            byte_ptr <= byte_ptr + 2'd1;
                            state    <= DECODE;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/varint_decoder.md
VARINT_DECODER -- requirements
Module: varint_decoder

Interface
REQ-001 The block SHALL use clock clk and reset reset, where reset is synchronous and active-high.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Port: varint_fifo_empty  in  1  varint data FIFO empty; the FIFO is show-ahead, so head data is valid whenever empty=0.
REQ-005 Port: varint_fifo_data  in  32  head word; byte0=[7:0] is decoded first, byte3=[31:24] last.
REQ-006 Port: varint_fifo_pop  out  1  one-cycle pop strobe for the data FIFO.
REQ-007 Port: varint_index_empty  in  1  varint index FIFO empty (show-ahead).
REQ-008 Port: varint_index_data  in  10  record index paired with the head word.
REQ-009 Port: varint_index_pop  out  1  pop strobe for the index FIFO; always equal to varint_fifo_pop.
REQ-010 Port: out_valid  out  1  decoded value available.
REQ-011 Port: out_ready  in  1  downstream accepts the value.
REQ-012 Port: out_value  out  64  decoded unsigned varint.
REQ-013 Port: out_index  out  10  record index of the value.
REQ-014 Port: out_nbytes  out  4  encoded length, 1..10.
REQ-015 Port: out_error  out  1  value is malformed (overflow or truncated).
REQ-016 Port: decoded_count  out  32  count of error-free values accepted, wrapping.

Function
REQ-017 States SHALL be FETCH, DECODE and EMIT.
REQ-018 FETCH: when both FIFOs are non-empty, pop for exactly one cycle, latch word_reg, new_index and byte_ptr=0, then go to DECODE; otherwise stay in FETCH and hold.
REQ-019 DECODE SHALL process one byte per cycle, b=word_reg byte[byte_ptr], as acc |= b[6:0] << (7*cnt) truncated to 64 bits, cnt++, with acc_index=new_index latched when cnt was 0.
REQ-020 If b[7]=0, the block SHALL load out_value=acc, out_nbytes=cnt, out_error=0 and go to EMIT.
REQ-021 If b[7]=1 and the new cnt=10, the block SHALL emit with out_error=1, out_nbytes=10, out_value=acc (overflow).
REQ-022 If b[7]=1, cnt<10 and byte_ptr=3, the block SHALL go to FETCH and retain acc and cnt, so a varint may span words.
REQ-023 In FETCH with cnt!=0, if the popped new_index!=acc_index, the block SHALL first emit the partial value (out_error=1, out_index=acc_index, out_nbytes=cnt), then decode the new word from byte 0.
REQ-024 EMIT: out_valid SHALL be 1 with outputs stable until out_ready; on acceptance acc=0, cnt=0, then go to FETCH if byte_ptr=3, else byte_ptr++ and go to DECODE.
REQ-025 out_valid SHALL be registered; the accepting cycle is the last cycle with out_valid=1, and there is no combinational path from out_ready to out_valid.
REQ-026 decoded_count SHALL increment on each out_valid&out_ready with out_error=0, wrapping from 2^32-1 to 0.
REQ-027 Latency SHALL be 3 cycles from pop to out_valid for a 1-byte varint in byte0.
REQ-028 The block SHALL never pop while in DECODE or EMIT.
REQ-029 A FIFO empty/non-empty mismatch SHALL be treated as empty.

Reset
REQ-030 On reset, state=FETCH; acc, cnt, byte_ptr, word_reg and decoded_count SHALL be 0.
REQ-031 On reset, all outputs SHALL be 0 in the following cycle.
REQ-032 Reset SHALL take priority in any state, including mid-EMIT; any partial varint is discarded and no output is produced for it.

Structure
REQ-033 A shared package SHALL hold the state enum and the constants VARINT_MAX_BYTES=10, INDEX_W=10, DATA_W=32 and VALUE_W=64.
REQ-034 There SHALL be one sub-module, varint_byte_acc, containing the acc/cnt shift-or datapath and its overflow flag; the FSM stays in the top module.

Verification
REQ-035 Word 0x00000001, idx 0 -> four outputs 1,0,0,0, each nbytes=1, idx=0, error=0; decoded_count=4.
REQ-036 Word 0x000002AC, idx 3 -> 300 (nbytes=2), then 0 and 0, all idx=3.
REQ-037 Words 0x80808080 then 0x00000001, both idx 5 -> 0x10000000 (nbytes=5, error=0), then 0,0,0.
REQ-038 Words 0xFFFFFFFF x3, idx 7 -> error=1, nbytes=10 after the 10th byte, then decoding resumes at byte 2 of word 3.
REQ-039 0x80808080 idx 1 then 0x00000005 idx 2 -> error=1, idx=1, nbytes=4; then 5, idx=2; then 0,0,0.
REQ-040 out_ready held low 6 cycles during EMIT -> outputs stable and no pop; reset asserted mid-EMIT -> out_valid=0 next cycle and decoded_count=0.
